ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/reply
// byte constants and the odd-parity helper used by both directions.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5,
      DONE      = 3'd6
   } ps2_tx_state_t;

   // Host-to-keyboard commands
   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

   // Keyboard-to-host replies
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
   localparam logic [7:0] PS2_BREAK       = 8'hF0;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-stage synchronizer for the PS/2 clock and data pins, plus a
// one-cycle pulse on each falling edge of the synchronized clock.
// Flops reset to 1 so the bus looks idle coming out of reset.
module ps2_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic clk_meta;
   logic data_meta;
   logic clk_prev;

   // Synchronize both pins and keep last cycle's synced clock for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta  <= 1'b1;
         clk_s     <= 1'b1;
         data_meta <= 1'b1;
         data_s    <= 1'b1;
         clk_prev  <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk;
         clk_s     <= clk_meta;
         data_meta <= ps2_data;
         data_s    <= data_meta;
         clk_prev  <= clk_s;
      end
   end

   // High for the one cycle where the synced clock goes 1 -> 0
   assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a
// request-to-send, shifts the byte, parity and stop bit out on the
// device's clock, then checks the device's line-level ACK.
//
// Handshake: a byte is taken on any cycle where tx_valid && tx_ready.
// tx_ready is high only in IDLE; tx_valid while busy is dropped (no
// queue), and the caller must not expect it to be taken later.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tx_valid,
   input  logic [7:0]    tx_data,
   output logic          tx_ready,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe,
   output logic          busy,
   output logic          done,
   output logic          ack_ok,
   output logic          err,
   output ps2_tx_state_t dbg_state
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   ps2_tx_state_t state;
   ps2_tx_state_t state_nxt;

   logic             clk_s;
   logic             data_s;
   logic             clk_fall;

   logic [7:0]       data_r;
   logic             parity_r;
   logic [3:0]       bit_idx;
   logic             data_oe_r;
   logic             fail_r;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic             accept;
   logic             inh_done;
   logic             counting;
   logic             timeout_hit;

   ps2_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .clk_s    (clk_s),
      .data_s   (data_s),
      .clk_fall (clk_fall)
   );

   assign accept      = tx_valid && (state == IDLE);
   assign inh_done    = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
   assign counting    = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
   // The counter reaches TIMEOUT_CYCLES on the same edge that enters DONE
   assign timeout_hit = counting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; a timeout overrides any bus activity in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = INHIBIT;
         INHIBIT:   if (inh_done) state_nxt = RTS;
         RTS:       state_nxt = SHIFT;
         SHIFT: begin
            if (timeout_hit)                      state_nxt = DONE;
            else if (clk_fall && bit_idx == 4'd9) state_nxt = ACK;
         end
         ACK: begin
            if (timeout_hit)   state_nxt = DONE;
            else if (clk_fall) state_nxt = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (timeout_hit)          state_nxt = DONE;
            else if (clk_s && data_s) state_nxt = DONE;
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; data line also driven by the shift register bit
   always_comb begin
      tx_ready    = (state == IDLE);
      busy        = (state != IDLE);
      done        = (state == DONE);
      ack_ok      = (state == DONE) && !fail_r;
      err         = (state == DONE) && fail_r;
      ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
      ps2_data_oe = (state == RTS) || data_oe_r;
      dbg_state   = state;
   end

   // Byte latch, counters, bit index, data line drive and result flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r    <= 8'h00;
         parity_r  <= 1'b0;
         bit_idx   <= 4'd0;
         data_oe_r <= 1'b0;
         fail_r    <= 1'b0;
         inh_cnt   <= '0;
         to_cnt    <= '0;
      end else begin
         if (accept) begin
            data_r   <= tx_data;
            parity_r <= odd_parity(tx_data);
            fail_r   <= 1'b0;
         end

         if (state == INHIBIT) inh_cnt <= inh_cnt + INH_W'(1);
         else                  inh_cnt <= '0;

         // Saturating: never wraps even if DONE were somehow delayed
         if (!counting)                             to_cnt <= '0;
         else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TO_W'(1);

         if (state != SHIFT)  bit_idx <= 4'd0;
         else if (clk_fall)   bit_idx <= bit_idx + 4'd1;

         // Start bit is held from RTS until the first device falling edge;
         // leaving for DONE (normal or timeout) releases the line at once.
         if (state_nxt == DONE || state_nxt == IDLE) begin
            data_oe_r <= 1'b0;
         end else if (state == RTS) begin
            data_oe_r <= 1'b1;
         end else if (state == SHIFT && clk_fall) begin
            if (bit_idx < 4'd8)       data_oe_r <= ~data_r[bit_idx[2:0]];
            else if (bit_idx == 4'd8) data_oe_r <= ~parity_r;
            else                      data_oe_r <= 1'b0;
         end

         if (timeout_hit)                              fail_r <= 1'b1;
         else if (state == ACK && clk_fall && data_s)  fail_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model.
// The model clocks the frame, samples bits on rising edges and optionally
// drives the ACK. Device clock is shortened and the timeout reduced to
// keep the run short; the timeout still lies far beyond a full frame.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INHIBIT = 50;
   localparam int TIMEOUT = 20000;
   localparam int HALF    = 100;   // device clock half period in system cycles

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          tx_valid = 1'b0;
   logic [7:0]    tx_data  = 8'h00;
   logic          tx_ready;
   logic          ps2_clk_oe;
   logic          ps2_data_oe;
   logic          busy;
   logic          done;
   logic          ack_ok;
   logic          err;
   ps2_tx_state_t dbg_state;

   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic ps2_clk_pin;
   logic ps2_data_pin;
   assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];   // {stop, parity, data} expected at the device
   logic [9:0] rx_q[$];    // frames actually captured by the device model

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ps2_clk     (ps2_clk_pin),
      .ps2_data    (ps2_data_pin),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .ack_ok      (ack_ok),
      .err         (err),
      .dbg_state   (dbg_state)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, output bit ready_seen);
      @(negedge clk);
      ready_seen = tx_ready;
      tx_valid   = 1'b1;
      tx_data    = b;
      @(negedge clk);
      tx_valid   = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output bit seen, output logic a, output logic e);
      seen = 1'b0;
      a    = 1'bx;
      e    = 1'bx;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            a    = ack_ok;
            e    = err;
            break;
         end
      end
   endtask

   // Keyboard model: wait for RTS, generate n_clocks clock pulses, capture
   // 10 bits on rising edges, pull data low across clock 11 when acking.
   task automatic dev_receive(input int n_clocks, input bit send_ack);
      bit         found = 1'b0;
      logic [9:0] w     = '0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (ps2_clk_pin === 1'b1 && ps2_data_pin === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rts_seen: got 0 required 1");
      end else begin
         repeat (HALF) @(negedge clk);
         for (int c = 1; c <= n_clocks; c++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            if (c <= 10) w[c-1] = ps2_data_pin;
            if (c == 10 && send_ack && n_clocks >= 11) dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge clk);
         end
         dev_data_low = 1'b0;
         if (n_clocks >= 10) rx_q.push_back(w);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_ready, busy, done, ack_ok, err, ps2_clk_oe, ps2_data_oe} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 1000000",
                  {tx_ready, busy, done, ack_ok, err, ps2_clk_oe, ps2_data_oe});
      end
      checks++;
      if (dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_send_ed();
      bit   rdy, seen;
      logic a, e;
      int   inh = 0;
      logic [9:0] got, want;
      exp_q.push_back(10'h3ED);
      fork
         begin
            send_byte(PS2_CMD_SET_LED, rdy);
            for (int i = 0; i < 200; i++) begin
               if (!(ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0)) break;
               inh++;
               @(negedge clk);
            end
            checks++;
            if (inh != INHIBIT) begin
               errors++;
               $display("FAIL inhibit_len: got %0d required %0d", inh, INHIBIT);
            end
            checks++;
            if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
               errors++;
               $display("FAIL rts_lines: got %b required 11", {ps2_clk_oe, ps2_data_oe});
            end
            @(negedge clk);
            checks++;
            if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
               errors++;
               $display("FAIL clk_release: got %b required 01", {ps2_clk_oe, ps2_data_oe});
            end
            wait_done(5000, seen, a, e);
            checks++;
            if ({seen, a, e} !== 3'b110) begin
               errors++;
               $display("FAIL ed_result: got seen/ack/err %b required 110", {seen, a, e});
            end
            @(negedge clk);
            checks++;
            if ({done, tx_ready} !== 2'b01) begin
               errors++;
               $display("FAIL done_pulse: got done/ready %b required 01", {done, tx_ready});
            end
         end
         dev_receive(11, 1'b1);
      join
      want = exp_q.pop_front();
      got  = (rx_q.size() > 0) ? rx_q.pop_front() : 10'hxxx;
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL ed_frame: got %h required %h", got, want);
      end
   endtask

   task automatic test_back_to_back();
      bit   rdy1, rdy2, seen1, seen2;
      logic a1, e1, a2, e2, busy_after;
      logic [9:0] got, want;
      exp_q.push_back(10'h201);
      exp_q.push_back(10'h3FF);
      fork
         begin
            send_byte(8'h01, rdy1);
            wait_done(5000, seen1, a1, e1);
            send_byte(PS2_CMD_RESET, rdy2);
            busy_after = busy;
            wait_done(5000, seen2, a2, e2);
         end
         begin
            dev_receive(11, 1'b1);
            dev_receive(11, 1'b1);
         end
      join
      checks++;
      if ({seen1, a1, e1} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_first: got seen/ack/err %b required 110", {seen1, a1, e1});
      end
      checks++;
      if ({rdy2, busy_after} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_accept: got ready/busy %b required 11", {rdy2, busy_after});
      end
      checks++;
      if ({seen2, a2, e2} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_second: got seen/ack/err %b required 110", {seen2, a2, e2});
      end
      for (int k = 0; k < 2; k++) begin
         want = exp_q.pop_front();
         got  = (rx_q.size() > 0) ? rx_q.pop_front() : 10'hxxx;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL b2b_frame%0d: got %h required %h", k, got, want);
         end
      end
   endtask

   task automatic test_timeout();
      bit   rdy;
      bit   released = 1'b0;
      int   cnt = 0;
      logic prev_data_oe = 1'b0;
      send_byte(8'h3C, rdy);
      for (int i = 0; i < 200; i++) begin
         if (ps2_clk_oe === 1'b0) begin
            released = 1'b1;
            break;
         end
         @(negedge clk);
      end
      for (int i = 0; i < TIMEOUT + 100 && released; i++) begin
         prev_data_oe = ps2_data_oe;
         @(negedge clk);
         cnt++;
         if (done === 1'b1) break;
      end
      checks++;
      if (!released || cnt != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_len: got %0d required %0d", cnt, TIMEOUT);
      end
      checks++;
      if ({done, err, ack_ok, ps2_clk_oe, ps2_data_oe, prev_data_oe} !== 6'b110001) begin
         errors++;
         $display("FAIL timeout_result: got done/err/ack/coe/doe/prev %b required 110001",
                  {done, err, ack_ok, ps2_clk_oe, ps2_data_oe, prev_data_oe});
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_nack();
      bit   rdy, seen;
      logic a, e;
      logic [9:0] got, want;
      exp_q.push_back(10'h396);
      fork
         begin
            send_byte(8'h96, rdy);
            wait_done(5000, seen, a, e);
         end
         dev_receive(11, 1'b0);
      join
      checks++;
      if ({seen, a, e} !== 3'b101) begin
         errors++;
         $display("FAIL nack_result: got seen/ack/err %b required 101", {seen, a, e});
      end
      want = exp_q.pop_front();
      got  = (rx_q.size() > 0) ? rx_q.pop_front() : 10'hxxx;
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL nack_frame: got %h required %h", got, want);
      end
   endtask

   task automatic test_reset_midframe();
      bit   rdy, seen;
      logic a, e;
      logic [9:0] got, want;
      fork
         send_byte(8'hC6, rdy);
         dev_receive(5, 1'b0);
      join
      // bit4 of 0xC6 is 0, so the data line is being pulled
      checks++;
      if ({busy, ps2_data_oe} !== 2'b11) begin
         errors++;
         $display("FAIL midframe_state: got busy/doe %b required 11", {busy, ps2_data_oe});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, done} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_midframe: got coe/doe/ready/busy/done %b required 00100",
                  {ps2_clk_oe, ps2_data_oe, tx_ready, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      exp_q.push_back(10'h2F4);
      fork
         begin
            send_byte(PS2_CMD_ENABLE, rdy);
            wait_done(5000, seen, a, e);
         end
         dev_receive(11, 1'b1);
      join
      checks++;
      if ({rdy, seen, a, e} !== 4'b1110) begin
         errors++;
         $display("FAIL after_reset_f4: got rdy/seen/ack/err %b required 1110", {rdy, seen, a, e});
      end
      want = exp_q.pop_front();
      got  = (rx_q.size() > 0) ? rx_q.pop_front() : 10'hxxx;
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL f4_frame: got %h required %h", got, want);
      end
   endtask

   task automatic test_ignore_busy();
      bit   rdy, seen;
      logic a, e, rdy_in_inh, rdy_in_shift;
      logic [9:0] got, want;
      exp_q.push_back(10'h3A3);
      fork
         begin
            send_byte(8'hA3, rdy);
            repeat (10) @(negedge clk);
            rdy_in_inh = tx_ready;
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (600) @(negedge clk);
            rdy_in_shift = tx_ready;
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            @(negedge clk);
            tx_valid = 1'b0;
            wait_done(5000, seen, a, e);
         end
         dev_receive(11, 1'b1);
      join
      checks++;
      if ({rdy_in_inh, rdy_in_shift, seen, a, e} !== 5'b00110) begin
         errors++;
         $display("FAIL ignore_result: got r1/r2/seen/ack/err %b required 00110",
                  {rdy_in_inh, rdy_in_shift, seen, a, e});
      end
      want = exp_q.pop_front();
      got  = (rx_q.size() > 0) ? rx_q.pop_front() : 10'hxxx;
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL ignore_frame: got %h required %h", got, want);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({busy, rx_q.size() == 0} !== 2'b01) begin
         errors++;
         $display("FAIL ignore_no_queue: got busy/empty %b required 01", {busy, rx_q.size() == 0});
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_send_ed();
      test_back_to_back();
      test_timeout();
      test_nack();
      test_reset_midframe();
      test_ignore_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
